// File: rtl/deemph_pkg.sv
// Shared types and constants for the deemph_iir de-emphasis filter.
// Holds the default coefficients, the FSM state type and the dequantize helper.
package deemph_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned COEF_W   = 32;
  localparam int unsigned PROD_W   = 2 * DATA_W;
  localparam int unsigned SUM_W    = DATA_W + 2;
  localparam int unsigned DEF_BITS = 10;

  localparam int DEF_X0 = 178;
  localparam int DEF_X1 = 178;
  localparam int DEF_Y1 = 666;

  typedef enum logic [1:0] {
    S_READ  = 2'd0,
    S_CALC  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  // Divide by 2^bits rounding toward zero: negative values get a bias before the shift.
  function automatic logic signed [SUM_W-1:0] dequantize(
    input logic signed [PROD_W-1:0] v,
    input int unsigned              bits
  );
    logic signed [PROD_W-1:0] bias;
    logic signed [PROD_W-1:0] adj;
    bias = v[PROD_W-1] ? ((PROD_W'(1) <<< bits) - PROD_W'(1)) : '0;
    adj  = (v + bias) >>> bits;
    return SUM_W'(adj);
  endfunction

endpackage

// File: rtl/iir_tap_mul.sv
// One filter tap: signed sample x coefficient product, dequantized to the sum width.
// Purely combinational; the top registers the result.
module iir_tap_mul
  import deemph_pkg::*;
#(
  parameter int unsigned BITS = DEF_BITS
) (
  input  logic signed [DATA_W-1:0] sample,
  input  logic signed [COEF_W-1:0] coef,
  output logic signed [SUM_W-1:0]  term_c
);

  logic signed [PROD_W-1:0] prod;

  always_comb begin
    prod   = PROD_W'(sample) * PROD_W'(coef);
    term_c = dequantize(prod, BITS);
  end

endmodule

// File: rtl/deemph_iir.sv
// First-order fixed-point IIR de-emphasis between two show-ahead FIFOs (3-cycle sample loop).
// Define DEEMPH_IIR_SATURATE_EN to clamp the sum instead of wrapping it.
module deemph_iir
  import deemph_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_W,
  parameter int unsigned BITS       = DEF_BITS,
  parameter int          X0         = DEF_X0,
  parameter int          X1         = DEF_X1,
  parameter int          Y1         = DEF_Y1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_dout,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  output logic [DATA_WIDTH-1:0] out_din,
  input  logic                  out_full,
  output logic                  out_wr_en
);

  localparam int unsigned SW = DATA_WIDTH + 2;

  state_t state;
  state_t state_nx;
  logic   pop;
  logic   push;

  logic signed [DATA_WIDTH-1:0] x;
  logic signed [DATA_WIDTH-1:0] x_hist;
  logic signed [DATA_WIDTH-1:0] y_hist;
  logic signed [DATA_WIDTH-1:0] y_next;
  logic signed [DATA_WIDTH-1:0] y_reduced;
  logic signed [SW-1:0]         t_x0;
  logic signed [SW-1:0]         t_x1;
  logic signed [SW-1:0]         t_y1;
  logic signed [SW-1:0]         sum;

  // Next-state and handshake decode
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    push     = 1'b0;
    unique case (state)
      S_READ: begin
        if (!in_empty) begin
          pop      = 1'b1;
          state_nx = S_CALC;
        end
      end
      S_CALC: state_nx = S_WRITE;
      S_WRITE: begin
        if (!out_full) begin
          push     = 1'b1;
          state_nx = S_READ;
        end
      end
      default: state_nx = S_READ;
    endcase
  end

  // Strobes are forced low while reset is held so nothing is popped or written.
  assign in_rd_en  = reset & pop;
  assign out_wr_en = reset & push;
  assign out_din   = y_next;

  iir_tap_mul #(.BITS(BITS)) u_tap_x0 (
    .sample (x),
    .coef   (COEF_W'(X0)),
    .term_c (t_x0)
  );

  iir_tap_mul #(.BITS(BITS)) u_tap_x1 (
    .sample (x_hist),
    .coef   (COEF_W'(X1)),
    .term_c (t_x1)
  );

  iir_tap_mul #(.BITS(BITS)) u_tap_y1 (
    .sample (y_hist),
    .coef   (COEF_W'(Y1)),
    .term_c (t_y1)
  );

  // Sum the taps with two guard bits, then bring back to the sample width
  always_comb begin
    sum = t_x0 + t_x1 + t_y1;
`ifdef DEEMPH_IIR_SATURATE_EN
    if (sum[SW-1:DATA_WIDTH-1] != {3{sum[SW-1]}}) begin
      y_reduced = sum[SW-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                            : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else begin
      y_reduced = DATA_WIDTH'(sum);
    end
`else
    y_reduced = DATA_WIDTH'(sum);
`endif
  end

  // State, sample and history registers; history only advances on a completed write
  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= S_READ;
      x      <= '0;
      x_hist <= '0;
      y_hist <= '0;
      y_next <= '0;
    end else begin
      state <= state_nx;
      if (pop) begin
        x <= in_dout;
      end
      if (state == S_CALC) begin
        y_next <= y_reduced;
      end
      if (push) begin
        x_hist <= x;
        y_hist <= y_next;
      end
    end
  end

endmodule

// File: tb/tb_deemph_iir.sv
// Self-checking bench for deemph_iir: default filter plus a unity-gain instance that overflows,
// both fed the same FIFO stream and compared against an arithmetic reference model.
module tb_deemph_iir;

  logic        clock;
  logic        reset;
  logic [31:0] in_dout;
  logic        in_empty;
  logic        out_full;
  logic        rd_a, wr_a, rd_b, wr_b;
  logic [31:0] din_a, din_b;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int overlap = 0;

`ifdef DEEMPH_IIR_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam int QB = 10;

  int     mx0[2] = '{178, 1024};
  int     mx1[2] = '{178, 1024};
  int     my1[2] = '{666, 0};
  longint xh[2];
  longint yh[2];

  deemph_iir u_dut_a (
    .clock     (clock),
    .reset     (reset),
    .in_dout   (in_dout),
    .in_empty  (in_empty),
    .in_rd_en  (rd_a),
    .out_din   (din_a),
    .out_full  (out_full),
    .out_wr_en (wr_a)
  );

  deemph_iir #(.X0(1024), .X1(1024), .Y1(0)) u_dut_b (
    .clock     (clock),
    .reset     (reset),
    .in_dout   (in_dout),
    .in_empty  (in_empty),
    .in_rd_en  (rd_b),
    .out_din   (din_b),
    .out_full  (out_full),
    .out_wr_en (wr_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (rd_a) rd_cnt++;
    if (wr_a) wr_cnt++;
    if (rd_a && wr_a) overlap++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic longint deq(input longint p);
    longint q = p;
    if (q < 0) q = q + ((64'sd1 <<< QB) - 64'sd1);
    return q >>> QB;
  endfunction

  function automatic longint wrapw(input longint v, input int w);
    return (v <<< (64 - w)) >>> (64 - w);
  endfunction

  task automatic model_reset();
    for (int f = 0; f < 2; f++) begin
      xh[f] = 0;
      yh[f] = 0;
    end
  endtask

  // Reference: y = DEQ(X0*x) + DEQ(X1*x1) + DEQ(Y1*y1) in 34 bits, then clamp or wrap to 32.
  task automatic model_step(input int f, input logic [31:0] xin, output logic [31:0] y);
    longint xv;
    longint s;
    xv = longint'($signed(xin));
    s  = wrapw(deq(mx0[f] * xv), 34) + wrapw(deq(mx1[f] * xh[f]), 34)
       + wrapw(deq(my1[f] * yh[f]), 34);
    s  = wrapw(s, 34);
    if (SAT && s > 64'sd2147483647)       y = 32'h7FFF_FFFF;
    else if (SAT && s < -64'sd2147483648) y = 32'h8000_0000;
    else                                  y = 32'(s);
    xh[f] = xv;
    yh[f] = longint'($signed(y));
  endtask

  task automatic start_pop(input logic [31:0] xin, input string tag);
    int n;
    n = 0;
    in_dout  = xin;
    in_empty = 1'b0;
    #1;
    while (!rd_a && n < 50) begin
      @(negedge clock); #1;
      n++;
    end
    chk($sformatf("%s_pop", tag), 32'(rd_a), 32'd1);
  endtask

  // Called at the negedge where the pop strobe is high; completes one sample end to end.
  task automatic finish(input logic [31:0] xin, input string tag);
    logic [31:0] ea, eb;
    int n;
    @(negedge clock);
    in_empty = 1'b1;
    in_dout  = $urandom;
    #1;
    n = 1;
    while (!wr_a && n < 50) begin
      @(negedge clock); #1;
      n++;
    end
    chk($sformatf("%s_lat", tag), 32'(n), 32'd2);
    chk($sformatf("%s_wrb", tag), 32'(wr_b), 32'd1);
    model_step(0, xin, ea);
    model_step(1, xin, eb);
    chk($sformatf("%s_a", tag), din_a, ea);
    chk($sformatf("%s_b", tag), din_b, eb);
    @(negedge clock); #1;
  endtask

  task automatic send(input logic [31:0] xin, input string tag);
    start_pop(xin, tag);
    finish(xin, tag);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    #1;
  endtask

  initial begin
    logic [31:0] held, ea, eb, x1, x2;
    int rc0, wc0;

    reset    = 1'b0;
    in_empty = 1'b0;
    in_dout  = 32'h0000_1234;
    out_full = 1'b0;
    model_reset();

    // Reset with data waiting: no handshakes, zero output
    @(negedge clock); #1;
    chk("rst_rd", 32'(rd_a), 32'd0);
    chk("rst_wr", 32'(wr_a), 32'd0);
    chk("rst_din", din_a, 32'd0);
    chk("rst_rd_cnt", 32'(rd_cnt), 32'd0);
    in_empty = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    #1;

    // Impulse response
    send(32'd1024, "imp0"); chk("imp0_const", din_a, 32'd178);
    send(32'd0,    "imp1"); chk("imp1_const", din_a, 32'd293);
    send(32'd0,    "imp2"); chk("imp2_const", din_a, 32'd190);

    // Negative values truncate toward zero
    do_reset();
    send(32'hFFFF_FC00, "neg1024"); chk("neg1024_const", din_a, 32'hFFFF_FF4E);
    do_reset();
    send(32'hFFFF_FFFF, "negone");  chk("negone_const", din_a, 32'd0);

    // Overflow on the unity-gain instance
    do_reset();
    send(32'h7FFF_FFFF, "ovf0");
    chk("ovf0_const", din_b, 32'h7FFF_FFFF);
    send(32'h7FFF_FFFF, "ovf1");
    chk("ovf1_const", din_b, SAT ? 32'h7FFF_FFFF : 32'hFFFF_FFFE);

    // Backpressure with the next sample already waiting upstream
    x1 = 32'd5000;
    x2 = 32'hFFFF_D8F0;
    out_full = 1'b1;
    start_pop(x1, "bp");
    @(negedge clock);
    in_dout = x2;
    @(negedge clock); #1;
    held = din_a;
    rc0  = rd_cnt;
    wc0  = wr_cnt;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp_wr%0d", i), 32'(wr_a), 32'd0);
      chk($sformatf("bp_rd%0d", i), 32'(rd_a), 32'd0);
      chk($sformatf("bp_din%0d", i), din_a, held);
      @(negedge clock); #1;
    end
    chk("bp_cnt_rd", 32'(rd_cnt), 32'(rc0));
    chk("bp_cnt_wr", 32'(wr_cnt), 32'(wc0));
    out_full = 1'b0;
    #1;
    model_step(0, x1, ea);
    model_step(1, x1, eb);
    chk("bp_rel_wr", 32'(wr_a), 32'd1);
    chk("bp_rel_a", din_a, ea);
    chk("bp_rel_b", din_b, eb);
    @(negedge clock); #1;
    chk("bp_one_write", 32'(wr_cnt), 32'(wc0 + 1));
    chk("bp_next_pop", 32'(rd_a), 32'd1);
    finish(x2, "bp_next");

    // Empty gap leaves history untouched
    rc0 = rd_cnt;
    wc0 = wr_cnt;
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("gap_rd%0d", i), 32'(rd_a), 32'd0);
      chk($sformatf("gap_wr%0d", i), 32'(wr_a), 32'd0);
      @(negedge clock); #1;
    end
    chk("gap_cnt", 32'(rd_cnt + wr_cnt), 32'(rc0 + wc0));
    send(32'd1024, "gap_after");

    // Reset while the popped sample is being computed
    start_pop(32'd77777, "midrst");
    @(negedge clock);
    in_empty = 1'b1;
    reset    = 1'b0;
    wc0      = wr_cnt;
    @(negedge clock); #1;
    chk("midrst_wr", 32'(wr_a), 32'd0);
    chk("midrst_din", din_a, 32'd0);
    reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clock);
    #1;
    chk("midrst_nowrite", 32'(wr_cnt), 32'(wc0));
    send(32'd1024, "midrst_after");
    chk("midrst_after_const", din_a, 32'd178);

    // Randomized stream with random idle gaps
    for (int i = 0; i < 40; i++) begin
      logic [31:0] xr;
      xr = (i % 2 == 0) ? $urandom : 32'($signed(32'($urandom_range(0, 4000)) - 32'd2000));
      repeat ($urandom_range(0, 3)) @(negedge clock);
      #1;
      send(xr, $sformatf("rnd%0d", i));
    end

    chk("never_both", 32'(overlap), 32'd0);
    chk("rd_minus_wr", 32'(rd_cnt - wr_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
